// File: rtl/sd_out_ddr_pkg.sv
// Shared types and constants for the SDR-to-DDR output stage.
// Buffer state encoding and phase order match the DDR input block.
package sd_out_ddr_pkg;

  typedef enum logic [1:0] {
     SD_DDR_EMPTY = 2'd0,
     SD_DDR_ONE   = 2'd1,
     SD_DDR_TWO   = 2'd2
  } ddr_state_e;

  // Upper half is launched while clk is high.
  localparam logic SD_DDR_HI_FIRST = 1'b1;

endpackage

// File: rtl/sd_out_ddr_if.sv
// Upstream srdy/drdy word port plus off-chip DDR port of sd_out_ddr.
// p_par exists only when SD_OUT_DDR_PARITY_EN is defined.
interface sd_out_ddr_if #(parameter int width = 8);
   logic                 c_srdy;
   logic                 c_drdy;
   logic [width-1:0]     c_data;
   logic                 p_srdy;
   logic                 p_drdy;
   logic [width/2-1:0]   p_data;
`ifdef SD_OUT_DDR_PARITY_EN
   logic                 p_par;
`endif

   modport master (
      output c_srdy, c_data, p_drdy,
      input  c_drdy, p_srdy, p_data
`ifdef SD_OUT_DDR_PARITY_EN
      , input p_par
`endif
   );

   modport slave (
      input  c_srdy, c_data, p_drdy,
      output c_drdy, p_srdy, p_data
`ifdef SD_OUT_DDR_PARITY_EN
      , output p_par
`endif
   );
endinterface

// File: rtl/sd_ddr_txmux.sv
// Negedge capture of the low half plus the clock-select output cell.
// lo_q holds across the posedge so the low phase survives obuf updating.
module sd_ddr_txmux
   import sd_out_ddr_pkg::*;
#(
   parameter int w = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [w-1:0] hi,
   input  logic [w-1:0] lo,
   output logic [w-1:0] q
);
   logic [w-1:0] lo_q;

   always_ff @(negedge clk) begin
      if (reset) lo_q <= '0;
      else       lo_q <= lo;
   end

   assign q = (clk == SD_DDR_HI_FIRST) ? hi : lo_q;
endmodule

// File: rtl/sd_out_ddr.sv
// SDR-to-DDR output stage: two-entry obuf/skid buffer with registered c_drdy,
// each word sent as hi/lo half phases. Optional parity: SD_OUT_DDR_PARITY_EN.
module sd_out_ddr
   import sd_out_ddr_pkg::*;
#(
   parameter int width = 8
) (
   input  logic          clk,
   input  logic          reset,
   sd_out_ddr_if.slave   bus
);
   localparam int HW = width / 2;

   ddr_state_e        state, nxt_state;
   logic [width-1:0]  obuf, skid, nxt_obuf, nxt_skid;
   logic              accept, drain, nxt_p_srdy, nxt_c_drdy;

   assign accept = bus.c_srdy & bus.c_drdy;
   assign drain  = bus.p_srdy & bus.p_drdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SD_DDR_EMPTY;
         obuf       <= '0;
         skid       <= '0;
         bus.p_srdy <= 1'b0;
         bus.c_drdy <= 1'b0;
      end else begin
         state      <= nxt_state;
         obuf       <= nxt_obuf;
         skid       <= nxt_skid;
         bus.p_srdy <= nxt_p_srdy;
         bus.c_drdy <= nxt_c_drdy;
      end
   end

   always_comb begin
      nxt_state = state;
      case (state)
         SD_DDR_EMPTY: if (accept) nxt_state = SD_DDR_ONE;
         SD_DDR_ONE: begin
            if (accept && !drain)      nxt_state = SD_DDR_TWO;
            else if (drain && !accept) nxt_state = SD_DDR_EMPTY;
         end
         SD_DDR_TWO:   if (drain) nxt_state = SD_DDR_ONE;
         default:      nxt_state = SD_DDR_EMPTY;
      endcase
   end

   // obuf only changes on a drain or into an empty slot, so it is stable under stall.
   always_comb begin
      nxt_obuf   = obuf;
      nxt_skid   = skid;
      case (state)
         SD_DDR_EMPTY: if (accept) nxt_obuf = bus.c_data;
         SD_DDR_ONE: begin
            if (accept && drain) nxt_obuf = bus.c_data;
            else if (accept)     nxt_skid = bus.c_data;
         end
         SD_DDR_TWO:   if (drain) nxt_obuf = skid;
         default: ;
      endcase
      nxt_p_srdy = (nxt_state != SD_DDR_EMPTY);
      nxt_c_drdy = (nxt_state != SD_DDR_TWO);
   end

   sd_ddr_txmux #(.w(HW)) u_txmux (
      .clk   (clk),
      .reset (reset),
      .hi    (obuf[width-1:HW]),
      .lo    (obuf[HW-1:0]),
      .q     (bus.p_data)
   );

`ifdef SD_OUT_DDR_PARITY_EN
   logic par_hi, par_lo_d;

   always_ff @(posedge clk) begin
      if (reset) par_hi <= 1'b0;
      else       par_hi <= ^nxt_obuf[width-1:HW];
   end

   assign par_lo_d = ^obuf[HW-1:0];

   sd_ddr_txmux #(.w(1)) u_parmux (
      .clk   (clk),
      .reset (reset),
      .hi    (par_hi),
      .lo    (par_lo_d),
      .q     (bus.p_par)
   );
`endif
endmodule

// File: tb/tb_sd_out_ddr.sv
// Directed + random bench for sd_out_ddr (width=8); words reassembled from
// the two DDR phases and checked against an in-order expected queue.
module tb_sd_out_ddr;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sd_out_ddr_if #(.width(W)) bus ();

   sd_out_ddr #(.width(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_q[$];
   bit         acc;
   int         pops = 0;
   bit         prev_stall = 0;
   logic [7:0] prev_word;
   int         s_cyc, s_idx, s_low;

   // Entered at posedge+1 with inputs driven; returns at next posedge+1.
   task automatic tick();
      logic ps, pd, cs, cd;
      logic [7:0] cdat, w, e;
      logic [3:0] hi_s, lo_s;
      #1;
      hi_s = bus.p_data;
      ps = bus.p_srdy; pd = bus.p_drdy; cs = bus.c_srdy; cd = bus.c_drdy; cdat = bus.c_data;
      @(negedge clk); #1;
      lo_s = bus.p_data;
      w = {hi_s, lo_s};
      acc = 0;
      if (ps && prev_stall) chk("hold", w, prev_word);
      if (ps && pd) begin
         chk("pop_avail", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("word", w, e);
         end
         pops++;
      end
      prev_stall = ps && !pd;
      prev_word  = w;
      if (cs && cd) begin
         exp_q.push_back(cdat);
         acc = 1;
      end
      @(posedge clk); #1;
   endtask

   task automatic stream(input logic [7:0] base, input int n, input int stall_n);
      s_cyc = 0; s_idx = 0; s_low = 0;
      while (s_idx < n && s_cyc < n + 50) begin
         bus.c_srdy = 1'b1;
         bus.c_data = base + 8'(s_idx);
         bus.p_drdy = (s_cyc >= stall_n);
         if (!bus.c_drdy) s_low++;
         tick();
         if (acc) s_idx++;
         s_cyc++;
      end
      chk("stream_cnt", s_idx, n);
      bus.c_srdy = 1'b0;
      bus.p_drdy = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      chk("drained", exp_q.size(), 0);
   endtask

   initial begin
      int p0;
      bus.c_srdy = 1'b1;
      bus.c_data = 8'h77;
      bus.p_drdy = 1'b1;

      // reset held 3 cycles with c_srdy asserted
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_p_srdy", bus.p_srdy, 0);
         chk("rst_c_drdy", bus.c_drdy, 0);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rel_c_drdy", bus.c_drdy, 1);
      chk("rel_p_srdy", bus.p_srdy, 0);

      // single word A5
      bus.c_data = 8'hA5;
      @(posedge clk); #1;
      bus.c_srdy = 1'b0;
      chk("single_p_srdy", bus.p_srdy, 1);
      #1 chk("single_hi", bus.p_data, 4'hA);
      @(negedge clk); #1;
      chk("single_lo", bus.p_data, 4'h5);
      @(posedge clk); #1;
      chk("single_done", bus.p_srdy, 0);

      // full-rate streaming 00..3F
      p0 = pops;
      stream(8'h00, 64, 0);
      chk("full_rate_cycles", s_cyc, 64);
      chk("full_rate_c_drdy_low", s_low, 0);
      chk("full_rate_pops", pops - p0, 64);

      // backpressure: 4 stalled cycles
      p0 = pops;
      stream(8'h40, 8, 4);
      chk("bp_cycles", s_cyc, 11);
      chk("bp_c_drdy_low", s_low, 3);
      chk("bp_pops", pops - p0, 8);

      // reset while holding 11 and 22
      bus.p_drdy = 1'b0;
      bus.c_srdy = 1'b1;
      bus.c_data = 8'h11; tick();
      bus.c_data = 8'h22; tick();
      chk("two_c_drdy", bus.c_drdy, 0);
      chk("two_p_srdy", bus.p_srdy, 1);
      reset = 1'b1;
      bus.c_srdy = 1'b0;
      @(posedge clk); #1;
      chk("midrst_p_srdy", bus.p_srdy, 0);
      chk("midrst_c_drdy", bus.c_drdy, 0);
      exp_q.delete();
      prev_stall = 0;
      reset = 1'b0;
      p0 = pops;
      stream(8'h33, 1, 0);
      chk("midrst_pops", pops - p0, 1);

`ifdef SD_OUT_DDR_PARITY_EN
      bus.c_srdy = 1'b1;
      bus.c_data = 8'hE1;
      bus.p_drdy = 1'b1;
      @(posedge clk); #1;
      bus.c_data = 8'h30;
      #1 chk("par_E_hi", bus.p_par, 1);
      @(negedge clk); #1;
      chk("par_1_lo", bus.p_par, 1);
      @(posedge clk); #1;
      bus.c_srdy = 1'b0;
      #1 chk("par_3_hi", bus.p_par, 0);
      @(negedge clk); #1;
      chk("par_0_lo", bus.p_par, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
`endif

      // random traffic against the scoreboard
      for (int i = 0; i < 2000; i++) begin
         bus.c_srdy = 1'($urandom_range(0, 1));
         bus.c_data = 8'($urandom);
         bus.p_drdy = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.c_srdy = 1'b0;
      bus.p_drdy = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      chk("rand_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
